carfield_domain_seq: RTL and testbench
======================================

# carfield_domain_seq

Power/clock-domain sequencer for the six gateable Carfield subdomains: periph, safety island, security island, integer cluster, FP cluster and L2. It compares per-domain enable requests from the Carfield register file against each domain's current state. It services one domain at a time in round-robin order, running a fixed clock-enable / reset-release sequence on power-up and a reset-assert / clock-gate sequence on power-down. Its outputs drive the domain clock gates and domain reset lines, and also feed the `domain_clk` / `domain_rsts_n` debug signals.

## Interface
- `NumDomains`, default 6: number of sequenced domains. Index order: Periph=0, Safed=1, Secd=2, IntCluster=3, FPCluster=4, L2=5.
- `RstCycles`, default 16: cycles the clock runs with reset held, on both power-up and power-down. Must be ≥1.
- `SettleCycles`, default 8: cycles after reset release before the domain is reported ready. Must be ≥1.
- `CntWidth`, default 8: counter width. Must satisfy 2^CntWidth ≥ max(RstCycles, SettleCycles).

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `domain_en_i`, in, NumDomains: requested enable per domain (level).
- `domain_clk_en_o`, out, NumDomains: clock-gate enable per domain.
- `domain_rst_no`, out, NumDomains: active-low domain reset.
- `domain_ready_o`, out, NumDomains: domain fully up.
- `busy_o`, out, 1: a sequence is in progress.
- `cur_domain_o`, out, $clog2(NumDomains): domain being or last sequenced.

## Operation
- One clock; reset is asynchronous and active-low (`clk_i`, `rst_ni`).
- All outputs are registered.
- Reset values (all zero): `domain_clk_en_o`=0, `domain_rst_no`=0 (all domains held in reset), `domain_ready_o`=0, `busy_o`=0, `cur_domain_o`=0. Round-robin pointer `ptr`=0, state IDLE, counter `cnt`=0.
- Pending set: `domain_en_i[d] != domain_ready_o[d]`.
- FSM states: IDLE, UP_CLK, UP_SETTLE, DN_RST.
- IDLE:
  - If the pending set is empty, stay in IDLE.
  - Otherwise select the first pending d, searching from `ptr` upward with wrap.
  - Then `cur_domain_o`←d, `busy_o`←1, `cnt`←0, `ptr`←(d+1) mod NumDomains.
  - If `domain_en_i[d]`=1: `domain_clk_en_o[d]`←1, go to UP_CLK.
  - Else: `domain_ready_o[d]`←0 and `domain_rst_no[d]`←0, go to DN_RST.
- UP_CLK: `cnt`++ each cycle. At `cnt`==RstCycles-1: `domain_rst_no[d]`←1, `cnt`←0, go to UP_SETTLE.
- UP_SETTLE: `cnt`++ each cycle. At `cnt`==SettleCycles-1: `domain_ready_o[d]`←1, `busy_o`←0, go to IDLE.
- DN_RST: `cnt`++ each cycle. At `cnt`==RstCycles-1: `domain_clk_en_o[d]`←0, `busy_o`←0, go to IDLE.
- A sequence never aborts. Changes to `domain_en_i[d]` during d's sequence are ignored until the sequence completes. If the request then still mismatches, d becomes pending again and is picked by normal round-robin.
- Other domains' outputs never change while domain d is being sequenced.
- Async reset at any point: all outputs return to reset values immediately, and every domain is gated and held in reset.

## Timing
- Request for d present at edge t, FSM in IDLE, no other pending domain:
  - `domain_clk_en_o[d]` high from t+1.
  - `domain_rst_no[d]` high from t+1+RstCycles.
  - `domain_ready_o[d]` high and `busy_o` low from t+1+RstCycles+SettleCycles.
- Power-down selected at edge t:
  - `domain_ready_o[d]`=0 and `domain_rst_no[d]`=0 from t+1.
  - `domain_clk_en_o[d]`=0 and `busy_o`=0 from t+1+RstCycles.
- Back-to-back sequences: at least one IDLE cycle between them. The next selection happens on the edge after return to IDLE.
- Ordering guarantees:
  - Clock enable always rises before reset deassertion.
  - Reset assertion always precedes clock gating by RstCycles.
  - `ready` never asserts while reset is asserted.

## Test plan
- Reset behaviour: hold `rst_ni`=0 with `domain_en_i`=6'h3F. All outputs must be 0. Release reset; `busy_o` must rise one cycle later.
- Single power-up (defaults 16/8): set `domain_en_i`=6'h08. `cur_domain_o`=3. `clk_en[3]` rises 1 cycle after selection, `rst_n[3]` at +17, `ready[3]` and `busy_o`↓ at +25. No other bits toggle.
- Power-down: after the above, set `domain_en_i`=0. `ready[3]` and `rst_n[3]` fall next cycle; `clk_en[3]` falls 16 cycles later.
- Round-robin: set `domain_en_i`=6'h3F from reset. Service order must be 0,1,2,3,4,5. Then clear bits 1 and 4 with `ptr`=0; order must be 1 then 4.
- Mid-sequence toggle: raise then drop `en[2]` 5 cycles into UP_CLK. The power-up completes with `ready[2]`=1 at +25, then a power-down of domain 2 follows immediately.
- Async reset mid-sequence: assert `rst_ni` during UP_SETTLE of domain 5. All outputs clear asynchronously. After release with `en[5]` still 1, a full power-up restarts from UP_CLK.

Source files
------------

// File: rtl/carfield_domain_seq.sv
// Power/clock-domain sequencer for the gateable Carfield subdomains.
// Services one domain at a time in round-robin order. Power-up enables the
// clock, holds reset for RstCycles, releases reset and waits SettleCycles
// before reporting ready. Power-down asserts reset, keeps the clock running
// for RstCycles, then gates the clock.
module carfield_domain_seq #(
  parameter int unsigned NumDomains   = 6,
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned CntWidth     = 8,
  localparam int unsigned IdxWidth    = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumDomains-1:0] domain_en_i,
  output logic [NumDomains-1:0] domain_clk_en_o,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic [NumDomains-1:0] domain_ready_o,
  output logic                  busy_o,
  output logic [IdxWidth-1:0]   cur_domain_o
);

  localparam logic [CntWidth-1:0] RstLast    = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
  localparam logic [IdxWidth-1:0] LastIdx    = IdxWidth'(NumDomains - 1);

  typedef enum logic [1:0] {
    IDLE,
    UP_CLK,
    UP_SETTLE,
    DN_RST
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic [IdxWidth-1:0]   cur_q, cur_d;
  logic [NumDomains-1:0] clk_en_q, clk_en_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic [NumDomains-1:0] ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [NumDomains-1:0] pending;
  logic                  found;
  logic [IdxWidth-1:0]   sel;
  logic [IdxWidth-1:0]   cand;
  int unsigned           idx;

  // A domain needs service whenever its request disagrees with its ready flag.
  assign pending = domain_en_i ^ ready_q;

  // Pick the first pending domain at or after the round-robin pointer, with wrap.
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, otherwise
    // a path that skips the assignment would infer a latch.
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    idx   = 0;
    for (int unsigned i = 0; i < NumDomains; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NumDomains) idx = idx - NumDomains;
      cand = IdxWidth'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and next-output logic; only the selected domain's bits move.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    clk_en_d = clk_en_q;
    rst_n_d  = rst_n_q;
    ready_d  = ready_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          cur_d  = sel;
          busy_d = 1'b1;
          cnt_d  = '0;
          ptr_d  = (sel == LastIdx) ? '0 : sel + 1'b1;
          if (domain_en_i[sel]) begin
            clk_en_d[sel] = 1'b1;
            state_d       = UP_CLK;
          end else begin
            ready_d[sel] = 1'b0;
            rst_n_d[sel] = 1'b0;
            state_d      = DN_RST;
          end
        end
      end

      UP_CLK: begin
        if (cnt_q == RstLast) begin
          rst_n_d[cur_q] = 1'b1;
          cnt_d          = '0;
          state_d        = UP_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      UP_SETTLE: begin
        if (cnt_q == SettleLast) begin
          ready_d[cur_q] = 1'b1;
          busy_d         = 1'b0;
          cnt_d          = '0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DN_RST: begin
        if (cnt_q == RstLast) begin
          clk_en_d[cur_q] = 1'b0;
          busy_d          = 1'b0;
          cnt_d           = '0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset gates every domain and holds it in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      cur_q    <= '0;
      clk_en_q <= '0;
      rst_n_q  <= '0;
      ready_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign domain_clk_en_o = clk_en_q;
  assign domain_rst_no   = rst_n_q;
  assign domain_ready_o  = ready_q;
  assign busy_o          = busy_q;
  assign cur_domain_o    = cur_q;

endmodule

// File: tb/tb_carfield_domain_seq.sv
// Self-checking bench for carfield_domain_seq. The reference model tracks each
// domain as simply on/off plus at most one active sequence described by its
// start edge; expected outputs are derived from the elapsed cycle count.
module tb_carfield_domain_seq;

  localparam int N = 6;
  localparam int R = 16;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] en = '0;
  wire  [5:0] clk_en;
  wire  [5:0] rst_dn;
  wire  [5:0] ready;
  wire        busy;
  wire  [2:0] cur;
  wire [21:0] obs = {clk_en, rst_dn, ready, busy, cur};

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int       e_cnt;
  int       act;
  bit       act_up;
  int       act_t;
  int       rr;
  bit [5:0] m_on;
  bit [2:0] m_cur;

  // Observed service order (domain reported at each busy rise)
  int dut_sel[$];
  bit prev_busy;

  carfield_domain_seq dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .domain_en_i    (en),
    .domain_clk_en_o(clk_en),
    .domain_rst_no  (rst_dn),
    .domain_ready_o (ready),
    .busy_o         (busy),
    .cur_domain_o   (cur)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    e_cnt = 0;
    act   = -1;
    act_up = 0;
    act_t = 0;
    rr    = 0;
    m_on  = '0;
    m_cur = '0;
  endfunction

  // One rising edge: finish the active sequence once its length has elapsed,
  // then, from idle, pick the next mismatching domain round-robin.
  function automatic void model_edge();
    int dur;
    bit [5:0] pend;
    bit found;
    e_cnt++;
    if (act >= 0) begin
      dur = act_up ? R + S : R;
      if (e_cnt > act_t + dur) begin
        m_on[act] = act_up;
        act = -1;
      end
    end
    if (act < 0) begin
      pend  = en ^ m_on;
      found = 0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (rr + i) % N;
        if (!found && pend[j]) begin
          found  = 1;
          act    = j;
          act_up = en[j];
          act_t  = e_cnt;
          m_cur  = 3'(j);
          rr     = (j + 1) % N;
        end
      end
    end
  endfunction

  function automatic logic [21:0] model_outs();
    logic [5:0] c, r, q;
    logic b;
    int k;
    c = m_on;
    r = m_on;
    q = m_on;
    b = 1'b0;
    if (act >= 0) begin
      k = e_cnt - act_t;
      if (act_up) begin
        c[act] = 1'b1;
        r[act] = (k >= R);
        q[act] = (k >= R + S);
        b      = (k < R + S);
      end else begin
        c[act] = (k < R);
        r[act] = 1'b0;
        q[act] = 1'b0;
        b      = (k < R);
      end
    end
    return {c, r, q, b, m_cur};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (busy && !prev_busy) dut_sel.push_back(int'(cur));
    prev_busy = busy;
  endtask

  task automatic do_reset(input logic [5:0] e);
    @(negedge clk);
    rst_n = 1'b0;
    en = e;
    model_reset();
    prev_busy = 1'b0;
    dut_sel.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 6'h3F;
    model_reset();
    prev_busy = 1'b0;
    dut_sel.delete();
    repeat (3) @(negedge clk);
    compared++;
    if (obs !== 22'h0) begin
      mismatched++;
      $display("FAIL reset_values: got %h expected %h", obs, 22'h0);
    end
    rst_n = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b1 || cur !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_release_busy: got busy=%b cur=%0d expected busy=1 cur=0", busy, cur);
    end
    compared++;
    if (obs !== model_outs()) begin
      mismatched++;
      $display("FAIL reset_release_outs: got %h expected %h", obs, model_outs());
    end
  endtask

  task automatic test_power_up();
    int t_clk = -1, t_rst = -1, t_rdy = -1;
    do_reset(6'h00);
    tick();
    en = 6'h08;
    for (int n = 0; n < 30; n++) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL power_up cycle %0d: got %h expected %h", n, obs, model_outs());
      end
      if (t_clk < 0 && clk_en[3]) t_clk = n;
      if (t_rst < 0 && rst_dn[3]) t_rst = n;
      if (t_rdy < 0 && ready[3]) t_rdy = n;
    end
    compared++;
    if (cur !== 3'd3) begin
      mismatched++;
      $display("FAIL power_up_cur: got %0d expected 3", cur);
    end
    compared++;
    if (t_clk !== 0 || t_rst - t_clk !== R || t_rdy - t_clk !== R + S) begin
      mismatched++;
      $display("FAIL power_up_timing: got clk@%0d rst@%0d rdy@%0d expected 0/%0d/%0d",
               t_clk, t_rst, t_rdy, R, R + S);
    end
  endtask

  task automatic test_power_down();
    int t_rdy = -1, t_clk = -1;
    en = 6'h00;
    for (int n = 0; n < 22; n++) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL power_down cycle %0d: got %h expected %h", n, obs, model_outs());
      end
      if (t_rdy < 0 && !ready[3] && !rst_dn[3]) t_rdy = n;
      if (t_clk < 0 && !clk_en[3]) t_clk = n;
    end
    compared++;
    if (t_rdy !== 0 || t_clk !== R) begin
      mismatched++;
      $display("FAIL power_down_timing: got rdy_fall@%0d clk_fall@%0d expected 0/%0d",
               t_rdy, t_clk, R);
    end
  endtask

  task automatic test_round_robin();
    int got;
    int exp2[2] = '{1, 4};
    do_reset(6'h3F);
    for (int n = 0; n < 170; n++) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL round_robin cycle %0d: got %h expected %h", n, obs, model_outs());
      end
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < dut_sel.size()) ? dut_sel[i] : -1;
      compared++;
      if (got !== i) begin
        mismatched++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got, i);
      end
    end
    dut_sel.delete();
    en = 6'h2D;
    for (int n = 0; n < 45; n++) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL rr_clear cycle %0d: got %h expected %h", n, obs, model_outs());
      end
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < dut_sel.size()) ? dut_sel[i] : -1;
      compared++;
      if (got !== exp2[i]) begin
        mismatched++;
        $display("FAIL rr_clear_order[%0d]: got %0d expected %0d", i, got, exp2[i]);
      end
    end
  endtask

  task automatic test_mid_toggle();
    bit saw_ready = 0;
    do_reset(6'h00);
    tick();
    en = 6'h04;
    tick();
    repeat (5) tick();
    en = 6'h00;
    for (int n = 0; n < 60; n++) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL mid_toggle cycle %0d: got %h expected %h", n, obs, model_outs());
      end
      if (ready[2]) saw_ready = 1;
    end
    compared++;
    if (dut_sel.size() != 2 || !saw_ready || ready[2] !== 1'b0 || clk_en[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_toggle_seq: got %0d sequences saw_ready=%b final clk_en=%b expected 2/1/0",
               dut_sel.size(), saw_ready, clk_en[2]);
    end
  endtask

  task automatic test_async_reset();
    int t_clk = -1, t_rdy = -1;
    do_reset(6'h00);
    tick();
    en = 6'h20;
    tick();
    repeat (R + 3) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL async_pre: got %h expected %h", obs, model_outs());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (obs !== 22'h0) begin
      mismatched++;
      $display("FAIL async_reset_clear: got %h expected %h", obs, 22'h0);
    end
    model_reset();
    prev_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < R + S + 3; n++) begin
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL async_restart cycle %0d: got %h expected %h", n, obs, model_outs());
      end
      if (t_clk < 0 && clk_en[5]) t_clk = n;
      if (t_rdy < 0 && ready[5]) t_rdy = n;
    end
    compared++;
    if (t_clk !== 0 || t_rdy !== R + S) begin
      mismatched++;
      $display("FAIL async_restart_timing: got clk@%0d rdy@%0d expected 0/%0d", t_clk, t_rdy, R + S);
    end
  endtask

  task automatic test_random();
    do_reset(6'h00);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) en = 6'($urandom());
      tick();
      compared++;
      if (obs !== model_outs()) begin
        mismatched++;
        $display("FAIL random cycle %0d: got %h expected %h", n, obs, model_outs());
      end
    end
  endtask

  initial begin
    model_reset();
    prev_busy = 1'b0;
    test_reset();
    test_power_up();
    test_power_down();
    test_round_robin();
    test_mid_toggle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
